// File: rtl/vend_controller.sv
// Vending-machine transaction core: edge-detected coin/select/refund handling,
// BCD credit tracking, registered one-cycle strobes and a post-strobe selection lockout.
module vend_controller #(
  parameter logic [7:0] PRICE_A     = 8'h25,
  parameter logic [7:0] PRICE_B     = 8'h50,
  parameter logic [7:0] PRICE_C     = 8'h65,
  parameter logic [7:0] PRICE_D     = 8'h80,
  parameter int         BUSY_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin5,
  input  logic       coin10,
  input  logic       coin25,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       sel_c,
  input  logic       sel_d,
  input  logic       coin_return,
  output logic       apple,
  output logic       banana,
  output logic       carrot,
  output logic       date,
  output logic       error,
  output logic       coin_reject,
  output logic       refund,
  output logic [7:0] refund_amt,
  output logic [7:0] credit,
  output logic       busy
);

  localparam int CW = $clog2(BUSY_CYCLES + 1);

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [3:0] t, u;
    t = 4'(v / 7'd10);
    u = 4'(v - 7'(t) * 7'd10);
    return {t, u};
  endfunction

  logic [2:0]    coin_in, coin_prev, coin_e;
  logic [3:0]    sel_in, sel_prev, sel_e;
  logic          ret_prev, ret_e;
  logic          coin_multi, sel_multi;
  logic [6:0]    cb, cval, price;
  logic [7:0]    sum;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    item_q, item_n;
  logic [7:0]    credit_n, amt_n;
  logic          err_n, rej_n, ref_n;

  assign coin_in    = {coin25, coin10, coin5};
  assign sel_in     = {sel_d, sel_c, sel_b, sel_a};
  assign coin_e     = coin_in & ~coin_prev;
  assign sel_e      = sel_in & ~sel_prev;
  assign ret_e      = coin_return & ~ret_prev;
  assign coin_multi = (coin_e & (coin_e - 3'd1)) != 3'd0;
  assign sel_multi  = (sel_e & (sel_e - 4'd1)) != 4'd0;
  assign cb         = bcd2bin(credit);
  assign sum        = {1'b0, cb} + {1'b0, cval};

  always_comb begin
    case (coin_e)
      3'b001:  cval = 7'd5;
      3'b010:  cval = 7'd10;
      3'b100:  cval = 7'd25;
      default: cval = 7'd0;
    endcase
    case (sel_e)
      4'b0001: price = bcd2bin(PRICE_A);
      4'b0010: price = bcd2bin(PRICE_B);
      4'b0100: price = bcd2bin(PRICE_C);
      4'b1000: price = bcd2bin(PRICE_D);
      default: price = 7'd0;
    endcase
  end

  // Priority: refund, then (unlocked) selection, then coins; locked selections fall through to coins.
  always_comb begin
    credit_n = credit;
    item_n   = 4'd0;
    err_n    = 1'b0;
    rej_n    = 1'b0;
    ref_n    = 1'b0;
    amt_n    = 8'h00;
    if (ret_e) begin
      if (credit != 8'h00) begin
        ref_n    = 1'b1;
        amt_n    = credit;
        credit_n = 8'h00;
      end
      rej_n = coin_e != 3'd0;
    end else if (sel_e != 4'd0 && !busy) begin
      rej_n = coin_e != 3'd0;
      if (sel_multi) begin
        err_n = 1'b1;
      end else if (cb >= price) begin
        item_n   = sel_e;
        credit_n = bin2bcd(cb - price);
      end else begin
        err_n = 1'b1;
      end
    end else if (coin_e != 3'd0) begin
      if (coin_multi || sum > 8'd99) begin
        rej_n = 1'b1;
        err_n = 1'b1;
      end else begin
        credit_n = bin2bcd(sum[6:0]);
      end
    end
  end

  always_comb begin
    cnt_n = cnt;
    if (err_n || item_n != 4'd0) cnt_n = CW'(BUSY_CYCLES);
    else if (cnt != '0)          cnt_n = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    coin_prev <= coin_in;
    sel_prev  <= sel_in;
    ret_prev  <= coin_return;
    if (reset) begin
      credit      <= 8'h00;
      item_q      <= 4'd0;
      error       <= 1'b0;
      coin_reject <= 1'b0;
      refund      <= 1'b0;
      refund_amt  <= 8'h00;
      cnt         <= '0;
      busy        <= 1'b0;
    end else begin
      credit      <= credit_n;
      item_q      <= item_n;
      error       <= err_n;
      coin_reject <= rej_n;
      refund      <= ref_n;
      refund_amt  <= amt_n;
      cnt         <= cnt_n;
      busy        <= cnt_n != '0;
    end
  end

  assign apple  = item_q[0];
  assign banana = item_q[1];
  assign carrot = item_q[2];
  assign date   = item_q[3];

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: per-cycle vector table plus hand-written
// reset corner sequences; expected values are hand-computed BCD.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin5, coin10, coin25, sel_a, sel_b, sel_c, sel_d, coin_return;
  logic       apple, banana, carrot, date, error, coin_reject, refund, busy;
  logic [7:0] refund_amt, credit;

  vend_controller dut (
    .clk(clk), .reset(reset),
    .coin5(coin5), .coin10(coin10), .coin25(coin25),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .sel_d(sel_d),
    .coin_return(coin_return),
    .apple(apple), .banana(banana), .carrot(carrot), .date(date),
    .error(error), .coin_reject(coin_reject), .refund(refund),
    .refund_amt(refund_amt), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  // input bits {coin_return, sel_d, sel_c, sel_b, sel_a, coin25, coin10, coin5}
  localparam logic [7:0] C5 = 8'h01, C10 = 8'h02, C25 = 8'h04, SA = 8'h08,
                         SB = 8'h10, SC = 8'h20, SD = 8'h40, RT = 8'h80;
  // strobe bits {refund, coin_reject, error, date, carrot, banana, apple}
  localparam logic [6:0] APL = 7'h01, DAT = 7'h08, ERR = 7'h10,
                         REJ = 7'h20, REF = 7'h40;

  typedef struct {
    logic [7:0] in;
    logic [7:0] credit;
    logic [6:0] str;
    logic       busy;
    logic [7:0] amt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add(input logic [7:0] in, input logic [7:0] cr,
                     input logic [6:0] str, input logic bsy,
                     input logic [7:0] amt = 8'h00);
    vec_t v;
    v.in = in; v.credit = cr; v.str = str; v.busy = bsy; v.amt = amt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [7:0] in);
    {coin_return, sel_d, sel_c, sel_b, sel_a, coin25, coin10, coin5} = in;
  endtask

  task automatic step(input logic [7:0] in);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] cr,
                       input logic [6:0] str, input logic bsy,
                       input logic [7:0] amt);
    logic [6:0] act;
    act = {refund, coin_reject, error, date, carrot, banana, apple};
    n_checks++;
    if (credit !== cr || act !== str || busy !== bsy || refund_amt !== amt) begin
      n_fail++;
      $display("FAIL %s: credit=%h strobes=%b busy=%b amt=%h, expected credit=%h strobes=%b busy=%b amt=%h",
               name, credit, act, busy, refund_amt, cr, str, bsy, amt);
    end
  endtask

  initial begin
    // plan 1: coins, held coin counts once
    add(0, 8'h00, 0, 0);
    add(C25, 8'h25, 0, 0);  add(0, 8'h25, 0, 0);
    add(C10, 8'h35, 0, 0);  add(0, 8'h35, 0, 0);
    add(C25, 8'h60, 0, 0);
    repeat (4) add(C25, 8'h60, 0, 0);
    add(0, 8'h60, 0, 0);
    // plan 2: vend apple, six busy cycles, locked selection ignored
    add(SA, 8'h35, APL, 1); add(0, 8'h35, 0, 1);
    add(SB, 8'h35, 0, 1);
    repeat (3) add(0, 8'h35, 0, 1);
    add(0, 8'h35, 0, 0);
    // plan 3: insufficient credit, then double select
    add(SB, 8'h35, ERR, 1);
    repeat (5) add(0, 8'h35, 0, 1);
    add(0, 8'h35, 0, 0);
    add(SA | SC, 8'h35, ERR, 1);
    repeat (5) add(0, 8'h35, 0, 1);
    add(0, 8'h35, 0, 0);
    // plan 4: reach 95, overflow rejected; coins accepted during busy
    add(C25, 8'h60, 0, 0);  add(0, 8'h60, 0, 0);
    add(C25, 8'h85, 0, 0);  add(0, 8'h85, 0, 0);
    add(C10, 8'h95, 0, 0);  add(0, 8'h95, 0, 0);
    add(C5, 8'h95, REJ | ERR, 1);
    repeat (5) add(0, 8'h95, 0, 1);
    add(0, 8'h95, 0, 0);
    add(SA, 8'h70, APL, 1); add(0, 8'h70, 0, 1);
    add(C10, 8'h80, 0, 1);  add(0, 8'h80, 0, 1);
    add(C10, 8'h90, 0, 1);  add(0, 8'h90, 0, 1);
    add(C5, 8'h95, 0, 0);   add(0, 8'h95, 0, 0);
    // plan 5: build 45, refund with coin in same cycle, then empty refund
    add(SD, 8'h15, DAT, 1); add(0, 8'h15, 0, 1);
    add(C10, 8'h25, 0, 1);  add(0, 8'h25, 0, 1);
    add(C10, 8'h35, 0, 1);  add(0, 8'h35, 0, 1);
    add(C10, 8'h45, 0, 0);  add(0, 8'h45, 0, 0);
    add(RT | C10, 8'h00, REF | REJ, 0, 8'h45);
    add(0, 8'h00, 0, 0);
    add(RT, 8'h00, 0, 0);   add(0, 8'h00, 0, 0);
    // exact-price vend with coin rejected, then two coins at once
    add(C25, 8'h25, 0, 0);  add(0, 8'h25, 0, 0);
    add(SA | C10, 8'h00, APL | REJ, 1);
    add(0, 8'h00, 0, 1);
    add(C5 | C10, 8'h00, REJ | ERR, 1);
    add(0, 8'h00, 0, 1);

    reset = 1'b1;
    drive(0);
    step(0);
    step(0);
    check("reset_state", 8'h00, 0, 0, 8'h00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].credit, vecs[i].str, vecs[i].busy, vecs[i].amt);
    end

    // plan 6a: sel_d held through reset with credit 80
    repeat (6) step(0);
    step(C25); step(0); step(C25); step(0); step(C25); step(0); step(C5); step(0);
    check("pre_reset_80", 8'h80, 0, 0, 8'h00);
    reset = 1'b1;
    step(SD);
    check("held_reset_1", 8'h00, 0, 0, 8'h00);
    step(SD);
    reset = 1'b0;
    step(SD);
    check("held_release_1", 8'h00, 0, 0, 8'h00);
    step(SD);
    check("held_release_2", 8'h00, 0, 0, 8'h00);
    step(0);

    // plan 6b: reset asserted mid-busy
    step(C25); step(0);
    step(SA);
    check("mid_busy_vend", 8'h00, APL, 1, 8'h00);
    step(0);
    reset = 1'b1;
    step(0);
    check("mid_busy_reset", 8'h00, 0, 0, 8'h00);
    reset = 1'b0;
    step(0);
    check("after_reset", 8'h00, 0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
